// File: rtl/gf180mcu_osu_sc_12t_clkdiv_gate.sv
// Glitch-free gated clock divider.
// CLKOUT is a registered divided clock whose half-period is (div_a + 1)
// source cycles. A new ratio is written into a shadow register (div_s) at any
// time and only becomes active at the start of a high phase. Stopping never
// produces a short high pulse: a stop request during a high phase lets the
// phase finish (STOP state); a stop request during a low phase ends at once.
module gf180mcu_osu_sc_12t_clkdiv_gate #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LOAD,
  output logic             CLKOUT,
  output logic             TICK,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] div_s_r;
  logic [WIDTH-1:0] div_a_r;
  logic [WIDTH-1:0] cnt_r;
  logic             clkout_r;
  logic             tick_r;
  logic             busy_r;

  logic             phase_end_s;
  logic [WIDTH-1:0] cnt_inc_s;

  // Current phase has lasted div_a+1 cycles once the counter reaches div_a.
  assign phase_end_s = (cnt_r == div_a_r);
  assign cnt_inc_s   = cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};

  // Shadow ratio register: captures DIV whenever LOAD is asserted, in any state.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      div_s_r <= {WIDTH{1'b0}};
    end else if (LOAD) begin
      div_s_r <= DIV;
    end else begin
      div_s_r <= div_s_r;
    end
  end

  // Divider FSM: counter, active ratio and all registered outputs.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {WIDTH{1'b0}};
      div_a_r  <= {WIDTH{1'b0}};
      clkout_r <= 1'b0;
      tick_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= {WIDTH{1'b0}};
          if (EN) begin
            // Start with a high phase; the pre-edge shadow ratio is used.
            state_r  <= ST_RUN;
            div_a_r  <= div_s_r;
            clkout_r <= 1'b1;
            tick_r   <= 1'b1;
            busy_r   <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
            div_a_r  <= div_a_r;
            clkout_r <= 1'b0;
            tick_r   <= 1'b0;
            busy_r   <= 1'b0;
          end
        end

        ST_RUN: begin
          if (!EN && !clkout_r) begin
            // Truncating a low phase cannot create a glitch: stop now.
            state_r  <= ST_IDLE;
            cnt_r    <= {WIDTH{1'b0}};
            div_a_r  <= div_a_r;
            clkout_r <= 1'b0;
            tick_r   <= 1'b0;
            busy_r   <= 1'b0;
          end else if (phase_end_s) begin
            cnt_r <= {WIDTH{1'b0}};
            if (clkout_r) begin
              // Falling toggle; a concurrent stop request ends here directly.
              div_a_r  <= div_a_r;
              clkout_r <= 1'b0;
              tick_r   <= 1'b0;
              if (EN) begin
                state_r <= ST_RUN;
                busy_r  <= 1'b1;
              end else begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              // Rising toggle: the only point where a new ratio takes effect.
              state_r  <= ST_RUN;
              div_a_r  <= div_s_r;
              clkout_r <= 1'b1;
              tick_r   <= 1'b1;
              busy_r   <= 1'b1;
            end
          end else begin
            cnt_r    <= cnt_inc_s;
            div_a_r  <= div_a_r;
            clkout_r <= clkout_r;
            tick_r   <= 1'b0;
            busy_r   <= 1'b1;
            if (!EN) begin
              // CLKOUT is high here: finish the high phase in STOP.
              state_r <= ST_STOP;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end

        ST_STOP: begin
          div_a_r <= div_a_r;
          tick_r  <= 1'b0;
          if (phase_end_s) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {WIDTH{1'b0}};
            clkout_r <= 1'b0;
            busy_r   <= 1'b0;
          end else begin
            state_r  <= ST_STOP;
            cnt_r    <= cnt_inc_s;
            clkout_r <= clkout_r;
            busy_r   <= 1'b1;
          end
        end

        default: begin
          // Unused encoding: recover to a safe, stopped state.
          state_r  <= ST_IDLE;
          cnt_r    <= {WIDTH{1'b0}};
          div_a_r  <= {WIDTH{1'b0}};
          clkout_r <= 1'b0;
          tick_r   <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign CLKOUT = clkout_r;
  assign TICK   = tick_r;
  assign BUSY   = busy_r;

endmodule

// File: doc/gf180mcu_osu_sc_12t_clkdiv_gate.md
GF180MCU_OSU_SC_12T_CLKDIV_GATE -- requirements
Module: gf180mcu_osu_sc_12T_clkdiv_gate

Interface
REQ-001 Parameter WIDTH, default 4, width of the divide-control field.
REQ-002 CLK  input  1  source clock; all state updates on rising edge.
REQ-003 RN  input  1  reset, asynchronous, active-low.
REQ-004 EN  input  1  run request for divided clock; sampled on CLK rising edge.
REQ-005 DIV  input  WIDTH  half-period control; half-period = DIV+1 CLK cycles.
REQ-006 LOAD  input  1  when 1, DIV captured into shadow register div_s on that edge.
REQ-007 CLKOUT  output  1  registered divided clock; drives the downstream clock inverter/buffer tree.
REQ-008 TICK  output  1  registered one-cycle pulse; 1 in exactly the CLK cycles where CLKOUT has just risen.
REQ-009 BUSY  output  1  1 whenever state is not IDLE.

Function
REQ-010 Internal state: div_s (shadow), div_a (active), cnt (WIDTH bits), FSM {IDLE, RUN, STOP}.
REQ-011 div_s SHALL load DIV on any edge with LOAD=1, in every state; LOAD=0 holds div_s.
REQ-012 div_a SHALL load div_s only on the edge where CLKOUT goes 0->1 (start of a high phase); a new ratio therefore never alters a phase in progress.
REQ-013 IDLE: CLKOUT=0, TICK=0, cnt=0; EN=1 sampled -> RUN, CLKOUT<=1, TICK<=1, cnt<=0, div_a<=div_s (in the same edge, div_s taken after any concurrent LOAD is NOT used; pre-edge div_s applies).
REQ-014 RUN: if cnt!=div_a, cnt<=cnt+1, CLKOUT holds; if cnt==div_a, cnt<=0 and CLKOUT toggles.
REQ-015 Each CLKOUT phase SHALL last exactly div_a+1 CLK cycles; period 2*(div_a+1); DIV=0 gives CLK/2, DIV=2^WIDTH-1 gives CLK/(2^(WIDTH+1)).
REQ-016 TICK<=1 on every edge that sets CLKOUT 0->1, else TICK<=0.
REQ-017 RUN, EN=0 sampled, CLKOUT=0: -> IDLE immediately, cnt<=0, CLKOUT stays 0 (low phase truncation is glitch-free).
REQ-018 RUN, EN=0 sampled, CLKOUT=1: -> STOP; counting continues unchanged.
REQ-019 STOP: count as RUN; on the edge where cnt==div_a, CLKOUT<=0, cnt<=0, -> IDLE; no high pulse shorter than div_a+1 cycles SHALL ever occur.
REQ-020 STOP ignores EN; restart requires EN=1 sampled in IDLE (earliest one cycle after STOP exit).
REQ-021 RUN with EN=0 and cnt==div_a and CLKOUT=1 on same edge: falling toggle taken, -> IDLE directly.
REQ-022 cnt never exceeds div_a; cnt arithmetic is unsigned WIDTH-bit, no wrap beyond div_a.
REQ-023 CLKOUT and TICK SHALL come directly from flops (no combinational path from inputs).

Reset
REQ-024 RN=0 SHALL asynchronously force state=IDLE, CLKOUT=0, TICK=0, BUSY=0, cnt=0, div_s=0, div_a=0.
REQ-025 Reset mid-high-phase truncates CLKOUT low immediately; this is the only permitted short pulse.
REQ-026 After RN deasserts, first EN=1 edge behaves per REQ-013.

Verification
REQ-027 LOAD DIV=2, then EN=1 held: CLKOUT high 3, low 3 cycles repeating; TICK pulses every 6 cycles; BUSY=1.
REQ-028 DIV=0, EN=1: CLKOUT toggles every edge (CLK/2); TICK=1 every 2nd cycle.
REQ-029 Running DIV=3, LOAD DIV=1 mid high phase: current high phase 4 cycles, following low 4 cycles, next high phase onward 2/2.
REQ-030 DIV=3, deassert EN one cycle into high phase: CLKOUT stays high 3 more cycles (4 total), then 0, BUSY falls same edge; deassert during low phase: CLKOUT stays 0, BUSY falls next edge.
REQ-031 RN pulsed low mid-high-phase: CLKOUT, TICK, BUSY 0 asynchronously; after release with EN=1 and no LOAD, ratio is CLK/2 (div_s=0).
REQ-032 Randomised EN/LOAD/DIV with checker: every CLKOUT phase length equals div_a+1 of its high phase except reset-truncated ones.
